// File: rtl/spi_pkg.sv
// Shared types and helpers for the parametrised SPI monarch.
// Holds the FSM state type and the divider reload value.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    F_PORCH,
    ACTIVE,
    B_PORCH
  } spi_state_t;

  // SCLK divider reload value: three quarters of the period, minus one.
  function automatic int unsigned ld_val(input int unsigned div_w);
    return (32'd1 << div_w) - (32'd1 << (div_w - 2)) - 32'd1;
  endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK divider for the SPI monarch.
// Produces SCLK, the MISO sample strobe and the shift strobe.
module spi_sclk_gen
  import spi_pkg::*;
#(
  parameter int DIV_W = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ld,
  output logic sclk,
  output logic smpl,
  output logic shft_pt
);

  localparam logic [DIV_W-1:0] LD_VAL =
    DIV_W'(ld_val(DIV_W));
  localparam logic [DIV_W-1:0] SMPL_VAL =
    DIV_W'((1 << (DIV_W - 1)) - 1);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_d;

  // Park at the reload value when idle, otherwise free-run.
  always_comb begin
    div_d = ld ? LD_VAL : div_q + DIV_W'(1);
  end

  // Divider register; reset leaves SCLK high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) div_q <= LD_VAL;
    else        div_q <= div_d;
  end

  assign sclk    = div_q[DIV_W-1];
  assign smpl    = (div_q == SMPL_VAL);
  assign shft_pt = &div_q;

endmodule

// File: rtl/spi_mnrch_param.sv
// Parametrised SPI monarch, mode 3, multi-slave, burst capable.
// FSM, shift register, bit counter and SS/done flops live here.
module spi_mnrch_param
  import spi_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DIV_W  = 4,
  parameter int NUM_SS = 1,
  parameter int SEL_W  = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wrt,
  input  logic [DATA_W-1:0] wt_data,
  input  logic [SEL_W-1:0]  ss_sel,
  input  logic              hold,
  input  logic              ss_rel,
  output logic [NUM_SS-1:0] SS_n,
  output logic              SCLK,
  output logic              MOSI,
  input  logic              MISO,
  output logic              done,
  output logic              busy,
  output logic [DATA_W-1:0] rd_data
);

  localparam int CNT_W = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  spi_state_t        state_q, state_d;
  logic [DATA_W-1:0] sr_q, sr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [NUM_SS-1:0] ss_n_q, ss_n_d;
  logic              hold_q, hold_d;
  logic              miso_smpl_q, miso_smpl_d;
  logic              done_q, done_d;
  logic              sclk_ld;
  logic              smpl;
  logic              shft_pt;
  logic              set_done;
  logic              shft;

  // Out-of-range indices drive no select low.
  function automatic logic [NUM_SS-1:0] sel_n(
    input logic [SEL_W-1:0] s
  );
    logic [NUM_SS-1:0] v;
    v = '1;
    for (int i = 0; i < NUM_SS; i++)
      if (int'(s) == i) v[i] = 1'b0;
    return v;
  endfunction

  assign sclk_ld = (state_q == IDLE) || set_done;

  spi_sclk_gen #(
    .DIV_W(DIV_W)
  ) u_sclk_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .ld     (sclk_ld),
    .sclk   (SCLK),
    .smpl   (smpl),
    .shft_pt(shft_pt)
  );

  // Transfer FSM with shift, count and slave-select next state.
  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    cnt_d       = cnt_q;
    ss_n_d      = ss_n_q;
    hold_d      = hold_q;
    set_done    = 1'b0;
    shft        = 1'b0;
    miso_smpl_d = smpl ? MISO : miso_smpl_q;
    unique case (state_q)
      IDLE: begin
        if (wrt) begin
          sr_d    = wt_data;
          cnt_d   = '0;
          hold_d  = hold;
          ss_n_d  = sel_n(ss_sel);
          state_d = F_PORCH;
        end else if (ss_rel) begin
          ss_n_d = '1;
        end
      end
      F_PORCH: begin
        if (smpl) state_d = ACTIVE;
      end
      ACTIVE: begin
        if (cnt_q == LAST) state_d = B_PORCH;
        else if (shft_pt)  shft    = 1'b1;
      end
      B_PORCH: begin
        if (shft_pt) begin
          shft     = 1'b1;
          set_done = 1'b1;
          state_d  = IDLE;
          if (!hold_q) ss_n_d = '1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (shft) begin
      sr_d  = {sr_q[DATA_W-2:0], miso_smpl_q};
      cnt_d = cnt_q + CNT_W'(1);
    end
    done_d = set_done;
  end

  // State and datapath registers; reset aborts any transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sr_q        <= '0;
      cnt_q       <= '0;
      ss_n_q      <= '1;
      hold_q      <= 1'b0;
      miso_smpl_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      cnt_q       <= cnt_d;
      ss_n_q      <= ss_n_d;
      hold_q      <= hold_d;
      miso_smpl_q <= miso_smpl_d;
      done_q      <= done_d;
    end
  end

  assign SS_n    = ss_n_q;
  assign MOSI    = sr_q[DATA_W-1];
  assign done    = done_q;
  assign busy    = (state_q != IDLE);
  assign rd_data = sr_q;

endmodule

// File: tb/tb_spi_mnrch_param.sv
// Directed bench for spi_mnrch_param.
// Two instances: 16-bit/4-slave and 8-bit/DIV_W=5.
module tb_spi_mnrch_param;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        a_wrt = 1'b0;
  logic [15:0] a_wt = '0;
  logic [2:0]  a_sel = '0;
  logic        a_hold = 1'b0;
  logic        a_ss_rel = 1'b0;
  logic [3:0]  a_ss_n;
  logic        a_sclk, a_mosi, a_miso, a_done, a_busy;
  logic [15:0] a_rd;

  logic        b_wrt = 1'b0;
  logic [7:0]  b_wt = '0;
  logic [0:0]  b_sel = '0;
  logic [0:0]  b_ss_n;
  logic        b_sclk, b_mosi, b_miso, b_done, b_busy;
  logic [7:0]  b_rd;

  logic        loop_en = 1'b1;
  logic        s_miso = 1'b0;
  logic [15:0] s_tx = '0;
  logic [15:0] s_rx = '0;
  int          s_idx = 0;
  int          a_falls = 0;

  int checks = 0;
  int errors = 0;

  assign a_miso = loop_en ? a_mosi : s_miso;
  assign b_miso = b_mosi;

  spi_mnrch_param #(
    .DATA_W(16), .DIV_W(4), .NUM_SS(4), .SEL_W(3)
  ) u_a (
    .clk(clk), .rst_n(rst_n), .wrt(a_wrt),
    .wt_data(a_wt), .ss_sel(a_sel), .hold(a_hold),
    .ss_rel(a_ss_rel), .SS_n(a_ss_n), .SCLK(a_sclk),
    .MOSI(a_mosi), .MISO(a_miso), .done(a_done),
    .busy(a_busy), .rd_data(a_rd)
  );

  spi_mnrch_param #(
    .DATA_W(8), .DIV_W(5), .NUM_SS(1)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .wrt(b_wrt),
    .wt_data(b_wt), .ss_sel(b_sel), .hold(1'b0),
    .ss_rel(1'b0), .SS_n(b_ss_n), .SCLK(b_sclk),
    .MOSI(b_mosi), .MISO(b_miso), .done(b_done),
    .busy(b_busy), .rd_data(b_rd)
  );

  // Mode-3 slave: drive on SCLK fall, capture on SCLK rise.
  always @(negedge a_sclk) begin
    a_falls++;
    if (a_ss_n != 4'hF && s_idx < 16) begin
      s_miso = s_tx[15 - s_idx];
      s_idx++;
    end
  end

  always @(posedge a_sclk) begin
    if (a_ss_n != 4'hF) s_rx = {s_rx[14:0], a_mosi};
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic xfer_a(input  logic [15:0] w,
                        input  logic [2:0]  sel,
                        input  logic        h,
                        output int          lat,
                        output logic [15:0] rd,
                        output logic [3:0]  ssm);
    a_wt   = w;
    a_sel  = sel;
    a_hold = h;
    a_wrt  = 1'b1;
    @(posedge clk);
    #1 a_wrt = 1'b0;
    lat = 0;
    ssm = 4'hx;
    while (!a_done && lat < 400) begin
      @(posedge clk);
      #1 lat++;
      if (lat == 100) ssm = a_ss_n;
    end
    rd = a_rd;
  endtask

  int          lat;
  logic [15:0] rd;
  logic [3:0]  ssm;
  int          nd;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ss_n", a_ss_n, 4'hF);
    chk("rst_sclk", a_sclk, 1'b1);
    chk("rst_mosi", a_mosi, 1'b0);
    chk("rst_done", a_done, 1'b0);
    chk("rst_busy", a_busy, 1'b0);
    chk("rst_rd", a_rd, 16'h0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    a_falls = 0;
    xfer_a(16'hA5C3, 3'd0, 1'b0, lat, rd, ssm);
    chk("loop_lat", lat, 261);
    chk("loop_rd", rd, 16'hA5C3);
    chk("loop_falls", a_falls, 16);
    chk("loop_ss_mid", ssm, 4'b1110);
    chk("loop_ss_end", a_ss_n, 4'hF);
    chk("loop_busy_end", a_busy, 1'b0);
    @(posedge clk);
    #1 chk("loop_done_1cyc", a_done, 1'b0);

    loop_en = 1'b0;
    s_tx = 16'h1234;
    s_idx = 0;
    s_rx = '0;
    xfer_a(16'hFFFF, 3'd2, 1'b0, lat, rd, ssm);
    chk("slv_rd", rd, 16'h1234);
    chk("slv_rx", s_rx, 16'hFFFF);
    chk("slv_ss_mid", ssm, 4'b1011);
    chk("slv_ss_end", a_ss_n, 4'hF);
    loop_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    xfer_a(16'h5555, 3'd5, 1'b0, lat, rd, ssm);
    chk("sel5_ss_mid", ssm, 4'hF);
    chk("sel5_lat", lat, 261);
    repeat (3) @(posedge clk);
    #1;

    xfer_a(16'h0001, 3'd1, 1'b1, lat, rd, ssm);
    chk("hold1_ss_end", a_ss_n, 4'b1101);
    xfer_a(16'h0002, 3'd1, 1'b0, lat, rd, ssm);
    chk("hold2_lat", lat, 261);
    chk("hold2_ss_mid", ssm, 4'b1101);
    chk("hold2_ss_end", a_ss_n, 4'hF);
    chk("hold2_rd", rd, 16'h0002);
    repeat (3) @(posedge clk);
    #1;

    xfer_a(16'h00F0, 3'd3, 1'b1, lat, rd, ssm);
    repeat (2) @(posedge clk);
    #1 chk("rel_ss_held", a_ss_n, 4'b0111);
    a_ss_rel = 1'b1;
    @(posedge clk);
    #1 a_ss_rel = 1'b0;
    chk("rel_ss_end", a_ss_n, 4'hF);
    repeat (3) @(posedge clk);
    #1;

    a_wt = 16'hBEEF;
    a_sel = 3'd0;
    a_hold = 1'b0;
    a_wrt = 1'b1;
    @(posedge clk);
    #1 a_wrt = 1'b0;
    repeat (125) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_ss_n", a_ss_n, 4'hF);
    chk("abort_sclk", a_sclk, 1'b1);
    chk("abort_done", a_done, 1'b0);
    chk("abort_busy", a_busy, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    nd = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1 if (a_done) nd++;
    end
    chk("abort_no_done", nd, 0);

    b_wt = 8'h96;
    b_wrt = 1'b1;
    @(posedge clk);
    #1 b_wrt = 1'b0;
    lat = 0;
    while (!b_done && lat < 400) begin
      @(posedge clk);
      #1 lat++;
      if (lat == 50 || lat == 150) begin
        b_wt  = 8'hFF;
        b_wrt = 1'b1;
      end else begin
        b_wrt = 1'b0;
      end
    end
    b_wrt = 1'b0;
    chk("b8_lat", lat, 265);
    chk("b8_rd", b_rd, 8'h96);
    chk("b8_ss_end", b_ss_n, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
